gpio_bank: RTL
==============

Name: gpio_bank

Overview:
Parametrised GPIO bank and the next generation of the team's 4-bit write-only output port. It adds:
- N pins with per-pin direction
- atomic set/clear writes
- synchronised input readback
- per-pin edge-triggered interrupts with sticky write-1-to-clear status

It sits on the simple CS/WE register bus beside other peripherals and drives a single IRQ line to the interrupt controller.

Parameters:
WIDTH, 8, number of pins (1..32)
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous, active-low reset
CS  input  1  chip select; qualifies WE and read
WE  input  1  1=write, 0=read (when CS=1)
Addr  input  3  register select
WData  input  WIDTH  write data
RData  output  WIDTH  read data, registered
RValid  output  1  pulses 1 cycle when RData is valid
PIN_IN  input  WIDTH  asynchronous pad inputs
PIN_OUT  output  WIDTH  pad output values (= OUT register)
PIN_OE  output  WIDTH  pad output enables (= DIR register)
IRQ  output  1  level interrupt = |(STATUS & IRQ_EN)

Behaviour:
- Reset (RST=0, asynchronous):
  - OUT, DIR, IRQ_EN, EDGE_SEL, STATUS, synchroniser, prev-sample and RData are all 0.
  - RValid and IRQ are 0; prime counter is 0.
  - All pins come up as inputs.
- Register map:
  - 0 OUT: RW.
  - 1 DIR: RW, 1 = output.
  - 2 IN: RO, synchronised pin value.
  - 3 IRQ_EN: RW.
  - 4 EDGE_SEL: RW, 1 = rising, 0 = falling.
  - 5 STATUS: read; write-1-to-clear.
  - 6 SET: WO, OUT |= WData.
  - 7 CLR: WO, OUT &= ~WData.
  - Reads of addresses 6 and 7 return 0. Writes to address 2 are ignored.
- Writes: on the CLK edge with CS=1 and WE=1; the new value is visible on PIN_OUT/PIN_OE the next cycle. CS=0 means no effect.
- Reads:
  - CS=1, WE=0 at edge N gives RData valid and RValid=1 after edge N (1-cycle latency).
  - Back-to-back reads are allowed, one per cycle.
  - RData holds its last value when RValid=0.
- Input path:
  - PIN_IN passes through SYNC_STAGES flops (sync) and then one prev-sample flop.
  - Edge on bit i: rise = sync&~prev, fall = ~sync&prev.
  - A selected edge sets STATUS[i] only when DIR[i]=0 and the unit is primed.
- Priming:
  - After RST deasserts, a counter runs SYNC_STAGES+1 cycles. Edges are ignored until it saturates.
  - This means a pin held high through reset never generates a false rising edge.
- STATUS is sticky:
  - A W1C clears written-1 bits.
  - If a new edge on bit i coincides with a W1C of bit i in the same cycle, set wins (STATUS[i]=1).
  - An edge in the cycle a 0 is written to that bit sets STATUS.
- IRQ_EN masks only IRQ; STATUS still records edges when IRQ_EN is 0. IRQ is combinational from the registers, so there is no extra latency after a STATUS/IRQ_EN change.
- Changing DIR from output to input does not itself create an edge. Only sync/prev transitions count.
- Changing EDGE_SEL takes effect for edges evaluated on the next clock edge.
- Total input-to-STATUS latency is SYNC_STAGES+1 cycles after the pin transition is sampled.
- Reset mid-operation: all state returns to reset values immediately. Priming restarts when RST releases.

Test Plan:
1. Reset with PIN_IN=8'hFF, EDGE_SEL=8'hFF after release; wait 10 cycles -> STATUS=0, IRQ=0; read addr 2 -> RData=8'hFF, RValid pulses once.
2. Write DIR=8'h0F, OUT=8'hA5; SET 8'h10; CLR 8'h01 -> PIN_OE=8'h0F, PIN_OUT=8'hB4; read addr 0 -> 8'hB4 one cycle later.
3. DIR=0, EDGE_SEL=8'h01, IRQ_EN=8'h01; toggle PIN_IN[0] 0->1 -> STATUS[0]=1 exactly SYNC_STAGES+1 cycles after sampling, IRQ=1; the 1->0 toggle sets nothing.
4. Sequence:
   - Write STATUS=8'h01 -> STATUS=0, IRQ=0.
   - Repeat, timing the W1C to the cycle of a new rise on bit 0 -> STATUS[0] stays 1.
   - IRQ_EN=0 with STATUS[3]=1 -> IRQ=0.
5. Set DIR[2]=1 and toggle PIN_IN[2] -> no STATUS[2]; set DIR[2]=0 with PIN_IN[2] steady -> no edge.
6. Assert RST mid-transaction with OUT=8'hFF -> PIN_OUT=0 asynchronously, before the next CLK edge.

Source files
------------

// File: rtl/gpio_bank_if.sv
// Register-bus bundle for the GPIO bank: CS/WE request side from the bus
// master, registered read data and its valid pulse back from the bank.
interface gpio_bank_if #(
    parameter int WIDTH = 8
);
    logic             CS;
    logic             WE;
    logic [2:0]       Addr;
    logic [WIDTH-1:0] WData;
    logic [WIDTH-1:0] RData;
    logic             RValid;

    modport master (
        output CS, WE, Addr, WData,
        input  RData, RValid
    );

    modport slave (
        input  CS, WE, Addr, WData,
        output RData, RValid
    );
endinterface

// File: rtl/gpio_bank.sv
// GPIO bank: per-pin direction, atomic set/clear, synchronised input readback
// and per-pin edge interrupts with sticky write-1-to-clear status.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    gpio_bank_if.slave       bus,
    input  logic [WIDTH-1:0] PIN_IN,
    output logic [WIDTH-1:0] PIN_OUT,
    output logic [WIDTH-1:0] PIN_OE,
    output logic             IRQ
);
    localparam int PRIME_MAX = SYNC_STAGES + 1;
    localparam int CNT_W     = $clog2(PRIME_MAX + 1);
    localparam logic [CNT_W-1:0] PRIME_DONE = CNT_W'(PRIME_MAX);

    localparam logic [2:0] A_OUT    = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_IN     = 3'd2;
    localparam logic [2:0] A_IRQ_EN = 3'd3;
    localparam logic [2:0] A_EDGE   = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;
    localparam logic [2:0] A_SET    = 3'd6;
    localparam logic [2:0] A_CLR    = 3'd7;

    logic [WIDTH-1:0] out_reg;
    logic [WIDTH-1:0] dir_reg;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] status;
    logic [WIDTH-1:0] sync_p [SYNC_STAGES];
    logic [WIDTH-1:0] prev_p;
    logic [CNT_W-1:0] prime_cnt;

    logic             primed;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] sync_val;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] status_next;
    logic [WIDTH-1:0] out_next;
    logic [WIDTH-1:0] read_val;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == PRIME_DONE) ? v : v + CNT_W'(1);
    endfunction

    assign wr     = bus.CS & bus.WE;
    assign rd     = bus.CS & ~bus.WE;
    assign primed = (prime_cnt == PRIME_DONE);

    always_comb begin
        sync_val = sync_p[SYNC_STAGES-1];
        rise     = sync_val & ~prev_p;
        fall     = ~sync_val & prev_p;
        // Output-driven pins and the post-reset fill window never record edges.
        edge_hit = primed ? (((rise & edge_sel) | (fall & ~edge_sel)) & ~dir_reg) : '0;

        // Set has priority over a same-cycle W1C of the same bit.
        w1c         = (wr && bus.Addr == A_STATUS) ? bus.WData : '0;
        status_next = (status & ~w1c) | edge_hit;

        out_next = out_reg;
        if (wr) begin
            case (bus.Addr)
                A_OUT:   out_next = bus.WData;
                A_SET:   out_next = out_reg | bus.WData;
                A_CLR:   out_next = out_reg & ~bus.WData;
                default: out_next = out_reg;
            endcase
        end

        case (bus.Addr)
            A_OUT:    read_val = out_reg;
            A_DIR:    read_val = dir_reg;
            A_IN:     read_val = sync_val;
            A_IRQ_EN: read_val = irq_en;
            A_EDGE:   read_val = edge_sel;
            A_STATUS: read_val = status;
            default:  read_val = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_reg    <= '0;
            dir_reg    <= '0;
            irq_en     <= '0;
            edge_sel   <= '0;
            status     <= '0;
            prev_p     <= '0;
            prime_cnt  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
            bus.RData  <= '0;
            bus.RValid <= 1'b0;
        end else begin
            // Input synchroniser, then the previous-sample stage for edge detection.
            sync_p[0] <= PIN_IN;
            for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
            prev_p    <= sync_val;
            prime_cnt <= sat_inc(prime_cnt);

            out_reg <= out_next;
            status  <= status_next;
            if (wr && bus.Addr == A_DIR)    dir_reg  <= bus.WData;
            if (wr && bus.Addr == A_IRQ_EN) irq_en   <= bus.WData;
            if (wr && bus.Addr == A_EDGE)   edge_sel <= bus.WData;

            // Read response stage: data holds between reads.
            bus.RValid <= rd;
            if (rd) bus.RData <= read_val;
        end
    end

    assign PIN_OUT = out_reg;
    assign PIN_OE  = dir_reg;
    assign IRQ     = |(status & irq_en);

endmodule
